// File: rtl/timer_pkg.sv
// Shared types and helpers for the BCD countdown timer: FSM state encoding and BCD digit limits.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bcd(input logic [3:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD decade of the countdown chain: parallel load for entry/clear, decrement with wrap on borrow.
module bcd_digit_down (
    input  logic       clk,
    input  logic       clearn,
    input  logic       en,
    input  logic       shift_en,
    input  logic [3:0] shift_in,
    input  logic [3:0] wrap_val,
    input  logic       borrow_in,
    output logic [3:0] value,
    output logic       borrow_out,
    output logic       is_zero
);

    logic [3:0] value_q;
    logic [3:0] value_d;

    assign is_zero    = (value_q == 4'd0);
    // A decade passes the borrow upward only when it is itself at zero and must wrap.
    assign borrow_out = borrow_in & is_zero;
    assign value      = value_q;

    always_comb begin
        value_d = value_q;
        if (shift_en) begin
            value_d = shift_in;
        end else if (en && borrow_in) begin
            value_d = is_zero ? wrap_val : (value_q - 4'd1);
        end
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// M:SS BCD countdown timer: keypad digit entry, 1 Hz countdown, pause/cancel and completion flag.
// Optional DOOR_INTERLOCK_EN adds a door_open input that forces PAUSE and blocks start.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int MIN_DIGITS   = 1,
    parameter int SEC_TENS_MAX = 5
) (
    input  logic                          clk,
    input  logic                          clearn,
    input  logic [3:0]                    digit,
    input  logic                          load,
    input  logic                          pgt_1hz,
    input  logic                          start,
    input  logic                          stop,
`ifdef DOOR_INTERLOCK_EN
    input  logic                          door_open,
`endif
    output logic [4*(MIN_DIGITS+2)-1:0]   time_bcd,
    output logic                          running,
    output logic                          done,
    output state_t                        state_dbg
);

    localparam int         ND       = MIN_DIGITS + 2;
    localparam logic [3:0] SEC_WRAP = 4'(SEC_TENS_MAX);

    state_t        state_q;
    logic          running_q;
    logic          done_q;
    logic          load_q;
    logic          pgt_q;

    logic          load_rise;
    logic          tick;
    logic          door_block;
    logic          load_ok;
    logic          clear_time;
    logic          shift_en;
    logic          dec_go;
    logic          time_nz;
    logic          last_sec;
    logic [ND:0]   borrow;
    logic [ND-1:0] zero_vec;
    logic          unused_borrow;

`ifdef DOOR_INTERLOCK_EN
    assign door_block = door_open;
`else
    assign door_block = 1'b0;
`endif

    assign load_rise = load & ~load_q;
    assign tick      = pgt_1hz & ~pgt_q;

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            load_q <= 1'b0;
            pgt_q  <= 1'b0;
        end else begin
            load_q <= load;
            pgt_q  <= pgt_1hz;
        end
    end

    // Entry and cancel both use the decade load path; cancel forces zeros into every decade.
    assign load_ok    = (state_q == IDLE) & load_rise & is_bcd(digit);
    assign clear_time = (state_q == PAUSE) & stop;
    assign shift_en   = load_ok | clear_time;
    assign dec_go     = (state_q == RUN) & tick & ~stop & ~door_block;

    assign time_nz       = ~(&zero_vec);
    assign last_sec      = (&zero_vec[ND-1:1]) & (time_bcd[3:0] == 4'd1);
    assign borrow[0]     = 1'b1;
    assign unused_borrow = borrow[ND];

    for (genvar i = 0; i < ND; i++) begin : g_digit
        logic [3:0] shift_src;
        if (i == 0) begin : g_lsd
            assign shift_src = digit;
        end else begin : g_upper
            assign shift_src = time_bcd[4*(i-1) +: 4];
        end

        bcd_digit_down u_digit (
            .clk        (clk),
            .clearn     (clearn),
            .en         (dec_go),
            .shift_en   (shift_en),
            .shift_in   (clear_time ? 4'd0 : shift_src),
            .wrap_val   ((i == 1) ? SEC_WRAP : BCD_MAX),
            .borrow_in  (borrow[i]),
            .value      (time_bcd[4*i +: 4]),
            .borrow_out (borrow[i+1]),
            .is_zero    (zero_vec[i])
        );
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A key edge owns the cycle; a coincident start is dropped.
                    if (!load_rise && start && time_nz && !door_block) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop || door_block) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end else if (tick && last_sec) begin
                        state_q   <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state_q <= IDLE;
                    end else if (start && !door_block) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (start || stop) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign running   = running_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: vector table, multi-cycle corner sequences, random run vs a decimal model.
`timescale 1ns/1ps
module tb_bcd_countdown_timer;

    localparam int MIN_DIGITS   = 1;
    localparam int SEC_TENS_MAX = 5;
    localparam int ND           = MIN_DIGITS + 2;
    localparam int W            = 4 * ND;
    localparam int MOD          = (MIN_DIGITS == 2) ? 10000 : 1000;

    logic         clk       = 1'b0;
    logic         clearn    = 1'b1;
    logic [3:0]   digit     = 4'd0;
    logic         load      = 1'b0;
    logic         pgt_1hz   = 1'b0;
    logic         start     = 1'b0;
    logic         stop      = 1'b0;
    logic         door_open = 1'b0;
    logic [W-1:0] time_bcd;
    logic         running;
    logic         done;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(
        .MIN_DIGITS   (MIN_DIGITS),
        .SEC_TENS_MAX (SEC_TENS_MAX)
    ) dut (
        .clk       (clk),
        .clearn    (clearn),
        .digit     (digit),
        .load      (load),
        .pgt_1hz   (pgt_1hz),
        .start     (start),
        .stop      (stop),
`ifdef DOOR_INTERLOCK_EN
        .door_open (door_open),
`endif
        .time_bcd  (time_bcd),
        .running   (running),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Reference model: time kept as a decimal number MSS, state as 0 idle / 1 run / 2 pause / 3 done.
    int   m_val;
    int   m_mode;
    logic m_pl;
    logic m_pp;

    function automatic int dec_time(input int v);
        int m;
        int s;
        m = v / 100;
        s = v % 100;
        if (s > 0) begin
            s = s - 1;
        end else begin
            s = SEC_TENS_MAX * 10 + 9;
            m = m - 1;
        end
        return m * 100 + s;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(posedge clk or negedge clearn) begin : model
        logic lr;
        logic tk;
        int   nv;
        int   nm;
        if (!clearn) begin
            m_val  <= 0;
            m_mode <= 0;
            m_pl   <= 1'b0;
            m_pp   <= 1'b0;
        end else begin
            lr = load & ~m_pl;
            tk = pgt_1hz & ~m_pp;
            nv = m_val;
            nm = m_mode;
            case (m_mode)
                0: begin
                    if (lr) begin
                        if (digit <= 4'd9) nv = (m_val * 10 + int'(digit)) % MOD;
                    end else if (start && m_val != 0 && !door_open) begin
                        nm = 1;
                    end
                end
                1: begin
                    if (stop || door_open) begin
                        nm = 2;
                    end else if (tk) begin
                        nv = dec_time(m_val);
                        if (nv == 0) nm = 3;
                    end
                end
                2: begin
                    if (stop) begin
                        nm = 0;
                        nv = 0;
                    end else if (start && !door_open) begin
                        nm = 1;
                    end
                end
                default: begin
                    if (start || stop) nm = 0;
                end
            endcase
            m_val  <= nv;
            m_mode <= nm;
            m_pl   <= load;
            m_pp   <= pgt_1hz;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] t, input logic r,
                           input logic dn, input logic [1:0] s);
        chk({tag, "_time"}, 32'(time_bcd), 32'(t));
        chk({tag, "_running"}, 32'(running), 32'(r));
        chk({tag, "_done"}, 32'(done), 32'(dn));
        chk({tag, "_state"}, 32'(state_dbg), 32'(s));
    endtask

    task automatic drive(input logic ld, input logic [3:0] dg, input logic pg,
                         input logic st, input logic sp);
        load    = ld;
        digit   = dg;
        pgt_1hz = pg;
        start   = st;
        stop    = sp;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic key(input logic [3:0] d);
        repeat (5) drive(1'b1, d, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick_once();
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        load      = 1'b0;
        digit     = 4'd0;
        pgt_1hz   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        door_open = 1'b0;
        clearn    = 1'b0;
        #2;
        clearn    = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic         ld;
        logic [3:0]   dg;
        logic         pg;
        logic         st;
        logic         sp;
        logic [W-1:0] t;
        logic         r;
        logic         dn;
        logic [1:0]   s;
    } vec_t;

    function automatic vec_t mk(input logic ld, input logic [3:0] dg, input logic pg,
                                input logic st, input logic sp, input logic [W-1:0] t,
                                input logic r, input logic dn, input logic [1:0] s);
        vec_t v;
        v.ld = ld; v.dg = dg; v.pg = pg; v.st = st; v.sp = sp;
        v.t = t; v.r = r; v.dn = dn; v.s = s;
        return v;
    endfunction

    vec_t vecs[22];

    initial begin
        vecs[0]  = mk(1, 4'd1, 0, 0, 0, 12'h001, 0, 0, 2'd0);
        vecs[1]  = mk(1, 4'd1, 0, 0, 0, 12'h001, 0, 0, 2'd0);
        vecs[2]  = mk(0, 4'd0, 0, 0, 0, 12'h001, 0, 0, 2'd0);
        vecs[3]  = mk(1, 4'd3, 0, 0, 0, 12'h013, 0, 0, 2'd0);
        vecs[4]  = mk(0, 4'd0, 0, 0, 0, 12'h013, 0, 0, 2'd0);
        vecs[5]  = mk(1, 4'd0, 0, 0, 0, 12'h130, 0, 0, 2'd0);
        vecs[6]  = mk(0, 4'd0, 0, 0, 0, 12'h130, 0, 0, 2'd0);
        vecs[7]  = mk(1, 4'd4, 0, 0, 0, 12'h304, 0, 0, 2'd0);
        vecs[8]  = mk(0, 4'd0, 0, 0, 0, 12'h304, 0, 0, 2'd0);
        vecs[9]  = mk(1, 4'hC, 0, 0, 0, 12'h304, 0, 0, 2'd0);
        vecs[10] = mk(0, 4'd0, 0, 0, 0, 12'h304, 0, 0, 2'd0);
        vecs[11] = mk(0, 4'd0, 0, 1, 0, 12'h304, 1, 0, 2'd1);
        vecs[12] = mk(0, 4'd0, 1, 0, 0, 12'h303, 1, 0, 2'd1);
        vecs[13] = mk(0, 4'd0, 1, 0, 0, 12'h303, 1, 0, 2'd1);
        vecs[14] = mk(0, 4'd0, 0, 0, 0, 12'h303, 1, 0, 2'd1);
        vecs[15] = mk(0, 4'd0, 1, 0, 1, 12'h303, 0, 0, 2'd2);
        vecs[16] = mk(0, 4'd0, 0, 1, 0, 12'h303, 1, 0, 2'd1);
        vecs[17] = mk(0, 4'd0, 0, 0, 1, 12'h303, 0, 0, 2'd2);
        vecs[18] = mk(0, 4'd0, 0, 0, 1, 12'h000, 0, 0, 2'd0);
        vecs[19] = mk(0, 4'd0, 0, 1, 0, 12'h000, 0, 0, 2'd0);
        vecs[20] = mk(1, 4'd7, 0, 1, 0, 12'h007, 0, 0, 2'd0);
        vecs[21] = mk(0, 4'd0, 0, 0, 0, 12'h007, 0, 0, 2'd0);

        // Power-on reset, observed while clearn is still low.
        #1 clearn = 1'b0;
        @(negedge clk);
        chk_all("reset", 12'h000, 1'b0, 1'b0, 2'd0);
        clearn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].ld, vecs[i].dg, vecs[i].pg, vecs[i].st, vecs[i].sp);
            chk_all($sformatf("vec%0d", i), vecs[i].t, vecs[i].r, vecs[i].dn, vecs[i].s);
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Entry with held keys, then a minute borrow: 1:00 -> 0:59.
        do_reset();
        key(4'd1); key(4'd0); key(4'd0);
        chk("entry_100", 32'(time_bcd), 32'h100);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        tick_once();
        chk_all("borrow_min", 12'h059, 1'b1, 1'b0, 2'd1);

        // Seconds-tens borrow: 0:10 -> 0:09.
        do_reset();
        key(4'd1); key(4'd0);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        tick_once();
        chk_all("borrow_tens", 12'h009, 1'b1, 1'b0, 2'd1);

        // Oversized seconds-tens counts down without normalisation: 0:70 -> 0:69.
        do_reset();
        key(4'd7); key(4'd0);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        tick_once();
        chk_all("tens_70", 12'h069, 1'b1, 1'b0, 2'd1);

        // Last second reaches DONE on the decrementing edge, then start returns to IDLE.
        do_reset();
        key(4'd1);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        tick_once();
        chk_all("done_edge", 12'h000, 1'b0, 1'b1, 2'd3);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk_all("done_exit", 12'h000, 1'b0, 1'b0, 2'd0);

        // Stop beats a coincident tick; resume; double stop cancels.
        do_reset();
        key(4'd4); key(4'd5);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        chk_all("stop_tick", 12'h045, 1'b0, 1'b0, 2'd2);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk_all("resume", 12'h045, 1'b1, 1'b0, 2'd1);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk_all("pause2", 12'h045, 1'b0, 1'b0, 2'd2);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk_all("cancel", 12'h000, 1'b0, 1'b0, 2'd0);

        // Asynchronous reset in the middle of RUN at 1:30.
        do_reset();
        key(4'd1); key(4'd3); key(4'd0);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk_all("pre_areset", 12'h130, 1'b1, 1'b0, 2'd1);
        #2 clearn = 1'b0;
        #1 chk_all("areset", 12'h000, 1'b0, 1'b0, 2'd0);
        #1 clearn = 1'b1;
        @(negedge clk);

`ifdef DOOR_INTERLOCK_EN
        do_reset();
        key(4'd2); key(4'd0);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        door_open = 1'b1;
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk_all("door_pause", 12'h020, 1'b0, 1'b0, 2'd2);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk_all("door_block", 12'h020, 1'b0, 1'b0, 2'd2);
        door_open = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk_all("door_resume", 12'h020, 1'b1, 1'b0, 2'd1);
`endif

        // Random traffic against the decimal reference model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            load  = ($urandom_range(0, 2) == 0);
            digit = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                               : 4'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) pgt_1hz = ~pgt_1hz;
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 29) == 0);
`ifdef DOOR_INTERLOCK_EN
            door_open = ($urandom_range(0, 19) == 0);
`endif
            @(posedge clk);
            @(negedge clk);
            chk("rnd_time", 32'(time_bcd), 32'(to_bcd(m_val)));
            chk("rnd_running", 32'(running), 32'(m_mode == 1));
            chk("rnd_done", 32'(done), 32'(m_mode == 3));
            chk("rnd_state", 32'(state_dbg), 32'(m_mode));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
